// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: operation-state encodings and a
// constant clog2 helper used to size counters and pointers.
package fifo_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      READ     = 3'd2,
      WR_ERROR = 3'd3,
      RD_ERROR = 3'd4,
      WR_RD    = 3'd5
   } state_t;

   // Smallest n with 2**n >= value; usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Handshake/status bundle between a FIFO producer/consumer (master) and the FIFO (slave).
// almost_full/almost_empty exist only when FIFO_ALMOST_EN is defined.
interface fifo_param_if
   import fifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
);

   localparam int CNT_W = clog2(DEPTH + 1);

   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              full;
   logic              empty;
   logic              wr_ack;
   logic              wr_err;
   logic              rd_ack;
   logic              rd_err;
   logic [CNT_W-1:0]  data_count;
   logic [STATE_W-1:0] state;
`ifdef FIFO_ALMOST_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   modport master (
      output wr_en, rd_en, din,
      input  dout, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count, state
`ifdef FIFO_ALMOST_EN
      , input almost_full, almost_empty
`endif
   );

   modport slave (
      input  wr_en, rd_en, din,
      output dout, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count, state
`ifdef FIFO_ALMOST_EN
      , output almost_full, almost_empty
`endif
   );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port and one registered,
// enable-gated read port whose output register clears on reset.
module fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_wrData,
   input  logic              i_rdEn,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0] o_rdData
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdData;

   // Storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Same-address read/write returns the old word, which the full WR_RD case relies on.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered operation-state FSM and ack/error pulses.
// Optional almost_full/almost_empty flags are enabled by defining FIFO_ALMOST_EN.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
`ifdef FIFO_ALMOST_EN
   ,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
`endif
) (
   input  logic         clk,
   input  logic         reset,
   fifo_param_if.slave  bus
);

   localparam int CNT_W  = clog2(DEPTH + 1);
   localparam int ADDR_W = clog2(DEPTH);

   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   state_t            r_state;
   logic              r_wrAck;
   logic              r_wrErr;
   logic              r_rdAck;
   logic              r_rdErr;

   logic              w_full;
   logic              w_empty;
   logic              w_doWrite;
   logic              w_doRead;
   logic              w_memWr;
   logic              w_memRd;
   logic [DATA_W-1:0] w_rdData;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // A write while full is still legal when paired with a read that frees a slot.
   assign w_doWrite = bus.wr_en && (!w_full || bus.rd_en);
   assign w_doRead  = bus.rd_en && !w_empty;
   assign w_memWr   = w_doWrite && !reset;
   assign w_memRd   = w_doRead && !reset;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk      (clk),
      .reset    (reset),
      .i_wrEn   (w_memWr),
      .i_wrAddr (r_wrPtr),
      .i_wrData (bus.din),
      .i_rdEn   (w_memRd),
      .i_rdAddr (r_rdPtr),
      .o_rdData (w_rdData)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_state <= IDLE;
         r_wrAck <= 1'b0;
         r_wrErr <= 1'b0;
         r_rdAck <= 1'b0;
         r_rdErr <= 1'b0;
      end else begin
         r_wrAck <= w_doWrite;
         r_wrErr <= bus.wr_en && !w_doWrite;
         r_rdAck <= w_doRead;
         r_rdErr <= bus.rd_en && !w_doRead;

         if (w_doWrite) begin
            r_wrPtr <= (r_wrPtr == ADDR_W'(DEPTH - 1)) ? '0 : r_wrPtr + ADDR_W'(1);
         end
         if (w_doRead) begin
            r_rdPtr <= (r_rdPtr == ADDR_W'(DEPTH - 1)) ? '0 : r_rdPtr + ADDR_W'(1);
         end

         unique case ({w_doWrite, w_doRead})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase

         if (w_doWrite && w_doRead) begin
            r_state <= WR_RD;
         end else if (w_doWrite) begin
            r_state <= WRITE;
         end else if (w_doRead) begin
            r_state <= READ;
         end else if (bus.wr_en) begin
            r_state <= WR_ERROR;
         end else if (bus.rd_en) begin
            r_state <= RD_ERROR;
         end else begin
            r_state <= IDLE;
         end
      end
   end

   assign bus.dout       = w_rdData;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.wr_ack     = r_wrAck;
   assign bus.wr_err     = r_wrErr;
   assign bus.rd_ack     = r_rdAck;
   assign bus.rd_err     = r_rdErr;
   assign bus.data_count = r_count;
   assign bus.state      = r_state;

`ifdef FIFO_ALMOST_EN
   assign bus.almost_full  = (int'(r_count) >= AF_LEVEL);
   assign bus.almost_empty = (int'(r_count) <= AE_LEVEL);
`else
   // Threshold flags are not built in this configuration.
`endif

endmodule
